// File: rtl/coram_arb_pkg.sv
// Shared definitions for the CoRAM single-port memory round-robin arbiter.
package coram_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int STALL_CNT_W = 64;

endpackage

// File: rtl/coram_rr_select.sv
// Combinational round-robin picker: first set request searching upward from last+1 with wrap.
module coram_rr_select #(
  parameter int NUM_REQ     = 4,
  parameter int LOG_NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [LOG_NUM_REQ-1:0] last_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic [LOG_NUM_REQ-1:0] idx_o,
  output logic                   any_o
);

  always_comb begin
    int j;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = (int'(last_i) + i) % NUM_REQ;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        idx_o    = LOG_NUM_REQ'(j);
        gnt_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/coram_mem_rr_arbiter.sv
// Round-robin arbiter sharing one sync-read single-port CoRAM memory among NUM_REQ requesters.
// Optional stall statistics counter enabled by defining CORAM_ARB_STALL_STAT_EN.
module coram_mem_rr_arbiter
  import coram_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int LOG_NUM_REQ = 2,
  parameter int W_D         = 32,
  parameter int W_A         = 12,
  parameter int MAX_BURST   = 16,
  parameter int W_BURST     = 5
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_REQ-1:0]       REQ,
  input  logic [NUM_REQ-1:0]       REQ_WE,
  input  logic [NUM_REQ*W_A-1:0]   REQ_ADDR,
  input  logic [NUM_REQ*W_D-1:0]   REQ_D,
  output logic [NUM_REQ-1:0]       GNT,
  output logic [W_D-1:0]           RDATA,
  output logic [NUM_REQ-1:0]       RVALID,
  output logic [W_A-1:0]           MEM_ADDR,
  output logic [W_D-1:0]           MEM_D,
  output logic                     MEM_WE,
  input  logic [W_D-1:0]           MEM_Q
`ifdef CORAM_ARB_STALL_STAT_EN
  ,
  output logic [STALL_CNT_W-1:0]   STALL_COUNT
`endif
);

  arb_state_e               state_q, state_d;
  logic [NUM_REQ-1:0]       gnt_q, gnt_d;
  logic [LOG_NUM_REQ-1:0]   last_q, last_d;
  logic [W_BURST-1:0]       count_q, count_d;
  logic [W_A-1:0]           addr_q;
  logic [W_D-1:0]           wdata_q;
  logic                     we_q;
  logic [NUM_REQ-1:0]       rv1_q, rv2_q;

  logic [NUM_REQ-1:0]       sel_gnt;
  logic [LOG_NUM_REQ-1:0]   sel_idx;
  logic                     sel_any;
  logic                     owner_req, accept, others;
  logic                     own_we;
  logic [W_A-1:0]           own_addr;
  logic [W_D-1:0]           own_d;

  coram_rr_select #(
    .NUM_REQ     (NUM_REQ),
    .LOG_NUM_REQ (LOG_NUM_REQ)
  ) u_select (
    .req_i  (REQ),
    .last_i (last_q),
    .gnt_o  (sel_gnt),
    .idx_o  (sel_idx),
    .any_o  (sel_any)
  );

  // While granted, the owner is always the last-picked requester.
  assign owner_req = REQ[last_q];
  assign own_we    = REQ_WE[last_q];
  assign own_addr  = REQ_ADDR[int'(last_q)*W_A +: W_A];
  assign own_d     = REQ_D[int'(last_q)*W_D +: W_D];
  assign accept    = (state_q == ST_GRANT) && owner_req;
  assign others    = |(REQ & ~gnt_q);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_any) begin
          state_d = ST_GRANT;
          gnt_d   = sel_gnt;
          last_d  = sel_idx;
          count_d = '0;
        end
      end
      ST_GRANT: begin
        if (!owner_req) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          count_d = '0;
        end else if (count_q == W_BURST'(MAX_BURST - 1)) begin
          count_d = '0;
          if (others) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= LOG_NUM_REQ'(NUM_REQ - 1);
      count_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rv1_q   <= '0;
      rv2_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      count_q <= count_d;
      if (accept) addr_q <= own_addr;
      wdata_q <= accept ? own_d : '0;
      we_q    <= accept & own_we;
      // Read valids travel independently of ownership so returns can overlap tenures.
      rv1_q   <= (accept && !own_we) ? gnt_q : '0;
      rv2_q   <= rv1_q;
    end
  end

  assign GNT      = gnt_q;
  assign RDATA    = MEM_Q;
  assign RVALID   = rv2_q;
  assign MEM_ADDR = addr_q;
  assign MEM_D    = wdata_q;
  assign MEM_WE   = we_q;

`ifdef CORAM_ARB_STALL_STAT_EN
  logic [STALL_CNT_W-1:0] stall_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_q <= '0;
    end else if ((|(REQ & ~gnt_q)) && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign STALL_COUNT = stall_q;
`endif

endmodule
